// File: rtl/ser_arb_ctrl.sv
// Two-source round-robin arbiter feeding a shared N-bit LSB-first serialiser.
// Emits a framed bit stream with per-bit valid, first-bit and source markers.
module ser_arb_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req0_data,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req1_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_first,
  output logic         ser_src,
  output logic         busy
);

  localparam int unsigned    CW       = $clog2(N);
  localparam logic [CW-1:0]  LAST     = CW'(N - 1);
  localparam logic [3:0]     GAP_LOAD = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  shreg;
  logic [3:0]    gap_cnt;
  logic          rr;
  logic          word_src;
  logic          can_load;
  logic          grant;
  logic          xfer;

  always_comb begin
    can_load   = !rst && (state == S_IDLE ||
                 (state == S_SHIFT && count == LAST && IDLE_GAP == 0));
    grant      = req1_valid && (!req0_valid || rr);
    req0_ready = can_load && req0_valid && !grant;
    req1_ready = can_load && grant;
    xfer       = req0_ready || req1_ready;
  end

  assign busy = (state != S_IDLE);

  // The IDLE turnaround cycle before a load is itself one silent bit slot, so
  // GAP only spans IDLE_GAP-1 cycles; that keeps the bubble exactly IDLE_GAP.
  // ser_src is staged through word_src so it stays aligned with ser_out when
  // a new word is accepted while the previous word's last bit is leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      shreg     <= '0;
      gap_cnt   <= '0;
      rr        <= 1'b0;
      word_src  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_src   <= 1'b0;
    end else begin
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      case (state)
        S_SHIFT: begin
          ser_out   <= shreg[0];
          ser_valid <= 1'b1;
          ser_first <= (count == '0);
          ser_src   <= word_src;
          shreg     <= {shreg[0], shreg[N-1:1]};
          count     <= count + 1'b1;
          if (count == LAST) begin
            if (IDLE_GAP > 1) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state   <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= 4'd1) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
      if (xfer) begin
        shreg    <= grant ? req1_data : req0_data;
        count    <= '0;
        word_src <= grant;
        rr       <= !grant;
        state    <= S_SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_ser_arb_ctrl.sv
// Bench for ser_arb_ctrl: two instances (IDLE_GAP=0 and 3) on shared stimulus,
// checked against a slot-queue model of the serial link plus directed sequences.
module tb_ser_arb_ctrl;
  localparam int unsigned N = 4;
  localparam int GAPS [2] = '{0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, v0, v1;
  logic [N-1:0] d0, d1;
  logic [1:0]   r0, r1, so, sv, sf, ss, bz;

  ser_arb_ctrl #(.N(N), .IDLE_GAP(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .req0_data(d0), .req0_valid(v0), .req0_ready(r0[0]),
    .req1_data(d1), .req1_valid(v1), .req1_ready(r1[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_first(sf[0]), .ser_src(ss[0]), .busy(bz[0])
  );

  ser_arb_ctrl #(.N(N), .IDLE_GAP(3)) dut_g3 (
    .clk(clk), .rst(rst),
    .req0_data(d0), .req0_valid(v0), .req0_ready(r0[1]),
    .req1_data(d1), .req1_valid(v1), .req1_ready(r1[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_first(sf[1]), .ser_src(ss[1]), .busy(bz[1])
  );

  // Model: each link is a queue of future output slots {valid, first, src, bit}.
  // A word books N bit slots, plus IDLE_GAP-1 silent slots when gaps are enforced
  // (the idle turnaround before the next load supplies the final silent slot).
  logic [3:0] q0[$], q1[$];
  logic       rr_m [2] = '{1'b0, 1'b0};
  logic [1:0] pre_r0, pre_r1;
  int         nchk = 0, npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int qsz(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int m, input logic [3:0] e);
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic logic [3:0] qpop(input int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // One clock: check readies mid-cycle, advance model at the edge, check outputs.
  task automatic step();
    logic         x [2];
    logic         g [2];
    logic         can, er0, er1, rst_s;
    logic [3:0]   e;
    logic [N-1:0] ds0, ds1, wd;
    #4;
    rst_s = rst; ds0 = d0; ds1 = d1;
    for (int m = 0; m < 2; m++) begin
      can  = !rst_s && (qsz(m) == 0 || (GAPS[m] == 0 && qsz(m) == 1));
      g[m] = (v0 && v1) ? rr_m[m] : v1;
      er0  = can && v0 && !g[m];
      er1  = can && v1 && g[m];
      x[m] = er0 || er1;
      chk($sformatf("ready0_g%0d", GAPS[m]), r0[m], er0);
      chk($sformatf("ready1_g%0d", GAPS[m]), r1[m], er1);
    end
    pre_r0 = r0; pre_r1 = r1;
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      e = 4'b0;
      if (rst_s) begin
        if (m == 0) q0.delete(); else q1.delete();
        rr_m[m] = 1'b0;
      end else begin
        if (qsz(m) > 0) e = qpop(m);
        if (x[m]) begin
          wd = g[m] ? ds1 : ds0;
          for (int j = 0; j < int'(N); j++) qpush(m, {1'b1, j == 0, g[m], wd[j]});
          for (int j = 1; j < GAPS[m]; j++) qpush(m, 4'b0);
          rr_m[m] = !g[m];
        end
      end
      chk($sformatf("ser_valid_g%0d", GAPS[m]), sv[m], e[3]);
      chk($sformatf("ser_first_g%0d", GAPS[m]), sf[m], e[2]);
      chk($sformatf("ser_out_g%0d", GAPS[m]), so[m], e[0]);
      if (e[3]) chk($sformatf("ser_src_g%0d", GAPS[m]), ss[m], e[1]);
      chk($sformatf("busy_g%0d", GAPS[m]), bz[m], qsz(m) > 0);
    end
  endtask

  typedef struct {
    logic rst, v0; logic [3:0] d0; logic v1; logic [3:0] d1;
    logic er0, er1, so, sv, sf, ss, bz;
  } vec_t;

  initial begin
    vec_t        tbl [7];
    int          vcnt, gap, ph;
    logic [15:0] seq;
    logic [3:0]  srcs;

    // single word 4'b1011 on the IDLE_GAP=0 instance
    tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; v0 = tbl[i].v0; d0 = tbl[i].d0; v1 = tbl[i].v1; d1 = tbl[i].d1;
      step();
      chk($sformatf("tbl%0d_ready0", i), pre_r0[0], tbl[i].er0);
      chk($sformatf("tbl%0d_ready1", i), pre_r1[0], tbl[i].er1);
      chk($sformatf("tbl%0d_ser_out", i), so[0], tbl[i].so);
      chk($sformatf("tbl%0d_ser_valid", i), sv[0], tbl[i].sv);
      chk($sformatf("tbl%0d_ser_first", i), sf[0], tbl[i].sf);
      chk($sformatf("tbl%0d_ser_src", i), ss[0], tbl[i].ss);
      chk($sformatf("tbl%0d_busy", i), bz[0], tbl[i].bz);
    end

    // both sources valid from reset release
    rst = 1'b1; step();
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 4'hA; d1 = 4'h5;
    vcnt = 0; seq = '0; srcs = '0; gap = 0; ph = 0;
    for (int k = 1; k <= 24; k++) begin
      #1;
      if (bz[1] && !sv[1]) chk("gap_ready1_g3", r1[1], 1'b0);
      step();
      if (k >= 2 && k <= 17) begin
        vcnt += int'(sv[0]);
        seq = {seq[14:0], so[0]};
        if (sf[0]) srcs = {srcs[2:0], ss[0]};
      end
      case (ph)
        0: if (sv[1]) ph = 1;
        1: if (!sv[1]) begin ph = 2; gap = 1; end
        2: if (sv[1]) ph = 3; else gap++;
        default: ;
      endcase
    end
    chk("rr_valid_run", vcnt, 16);
    chk("rr_bits", seq, 16'h5A5A);
    chk("rr_src_order", srcs, 4'b0101);
    chk("gap_len_g3", gap, 3);

    // data changes after acceptance must not affect the word
    v0 = 1'b0; v1 = 1'b0; rst = 1'b1; step();
    rst = 1'b0; d0 = 4'hF; v0 = 1'b1; step();
    d0 = 4'h0; v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stable_bit%0d", i), {sv[0], so[0]}, 2'b11);
    end

    // asynchronous reset in the middle of 4'b0110
    rst = 1'b1; step();
    rst = 1'b0; d0 = 4'b0110; v0 = 1'b1; step();
    v0 = 1'b0; step(); step();
    chk("pre_reset_bit1", {sv[0], so[0]}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_ser_valid", sv[0], 1'b0);
    chk("async_ser_out", so[0], 1'b0);
    chk("async_busy", bz[0], 1'b0);
    chk("async_ser_valid_g3", sv[1], 1'b0);
    step();
    rst = 1'b0; v1 = 1'b1; d1 = 4'h9; step();
    chk("post_reset_ready1", pre_r1[0], 1'b1);
    v1 = 1'b0; step();
    chk("post_reset_first", sf[0], 1'b1);
    chk("post_reset_src", ss[0], 1'b1);
    chk("post_reset_bit0", so[0], 1'b1);

    // idle hold-off
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d", i), {pre_r0[0], pre_r1[0], so[0], sv[0], bz[0]}, 5'b0);
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      d0  = N'($urandom);
      d1  = N'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/ser_arb_ctrl.md
Name: ser_arb_ctrl

Overview:
Controller that shares one n-bit LSB-first parallel-to-serial shifter between two word sources.
- Round-robin arbitration between the two sources.
- valid/ready handshake on each source.
- Sequences load and shift of the shared shift register.
- Emits a framed serial bit stream with per-bit valid, first-bit and source-ID markers for the downstream link/tester.
- Includes its own shift register and bit counter. It replaces ad-hoc reset-as-load sequencing of the bare shifter.

Parameters:
N, 4, serial word width in bits (N >= 2).
IDLE_GAP, 0, number of idle cycles forced between consecutive words (0 = back-to-back allowed, max 15).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
req0_data  input  N  word from source 0.
req0_valid  input  1  source 0 word available.
req0_ready  output  1  source 0 word accepted this cycle (combinational).
req1_data  input  N  word from source 1.
req1_valid  input  1  source 1 word available.
req1_ready  output  1  source 1 word accepted this cycle (combinational).
ser_out  output  1  serial data bit, LSB first (registered).
ser_valid  output  1  ser_out carries a valid bit (registered).
ser_first  output  1  high on bit 0 of each word (registered).
ser_src  output  1  source of the word currently shifting (registered).
busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; bit counter 0; shift register 0; gap counter 0.
  - Round-robin pointer 0, so source 0 has first priority.
  - ser_out, ser_valid, ser_first, ser_src and busy all 0.
  - ready outputs 0 while rst is high.
- Transfer rule: a transfer on source i occurs on the rising edge where reqi_valid=1 and reqi_ready=1.
- can_load is true in either case:
  - state==IDLE;
  - state==SHIFT, bit counter==N-1, and IDLE_GAP==0.
- Grant:
  - Only one valid source → that source is granted.
  - Both valid → the source selected by the RR pointer is granted.
  - reqi_ready = can_load && grant==i. At most one ready is high per cycle.
  - Ready never depends on ready.
- On transfer:
  - Shift register ← reqi_data; bit counter ← 0; ser_src ← i.
  - RR pointer ← ~i, so the source just served becomes lowest priority.
  - State ← SHIFT.
- SHIFT, per cycle:
  - ser_out ← shreg[0]; ser_valid ← 1; ser_first ← (count==0).
  - Shift register rotates right by one; count increments.
  - Latency: word accepted at edge T → bits appear on ser_out in cycles T+1..T+N; ser_first is high in cycle T+1 only.
- End of word (count==N-1 in SHIFT):
  - If a transfer occurs on that edge, the next word starts with no bubble.
  - Otherwise: IDLE_GAP>0 → GAP with gap counter ← IDLE_GAP-1; IDLE_GAP==0 → IDLE.
- IDLE and GAP: ser_valid ← 0; ser_first ← 0; ser_out ← 0; requests are not accepted in GAP.
- GAP: decrement the gap counter; move to IDLE when it reaches 0. The gap is exactly IDLE_GAP cycles with ser_valid=0.
- Sampling: data is sampled only at the transfer edge. Later changes on reqi_data have no effect on the word being shifted.
- Valid deasserting before ready is tolerated; no transfer occurs.
- Reset mid-word: the word is discarded with no partial completion, and outputs go to their reset values immediately.
- Word boundaries: exactly N ser_valid cycles per accepted word. Words are never truncated or merged.
- busy: 1 in SHIFT or GAP, 0 in IDLE.

Test Plan:
- Single word: N=4, IDLE_GAP=0; req0_data=4'b1011, req0_valid pulsed one cycle in IDLE → req0_ready=1 that cycle; next 4 cycles ser_out=1,1,0,1, ser_valid=1, ser_first=1,0,0,0, ser_src=0; then ser_valid=0, busy=0.
- Simultaneous requests: req0_data=4'hA and req1_data=4'h5, both valid held from reset release → words served in order src0, src1, src0, src1.
  - ser_src alternates 0,1,0,1.
  - ser_valid stays high continuously for 16 cycles.
  - ser_out = 0,1,0,1 then 1,0,1,0.
- Back-to-back vs gap:
  - IDLE_GAP=0 with req1 continuously valid → no ser_valid bubble between words.
  - IDLE_GAP=3 → exactly 3 ser_valid=0 cycles between words.
  - req1_ready stays low during the GAP cycles.
- Data stability: change req0_data from 4'hF to 4'h0 one cycle after the transfer → ser_out still 1,1,1,1.
- Reset mid-word: assert rst after the 2nd bit of 4'b0110 → ser_valid, ser_out, busy go 0 asynchronously. After release with only req1 valid, req1 is served first, and that word's first ser_first=1 with ser_src=1.
- Idle hold-off: no valids for 10 cycles → ser_valid=0, busy=0, ready outputs 0, ser_out=0 throughout.
